// File: rtl/median_frame_ctrl.sv
// -----------------------------------------------------------------------------
// median_frame_ctrl
//
// Frame-level sequencer for the 3x3 binary median window scanner. It holds the
// scanner in reset between frames and gates the scanner's advance enable with
// image-memory back-pressure. It writes each window's median bit into the
// median result memory and counts the windows whose median is 1. At frame end
// it offers the count, a threshold flag and an optional cross-check flag over a
// valid/ready handshake.
//
// Optional feature macro: MEDCTRL_CROSSCHECK_EN
//   defined     : mismatch is registered in SETTLE as (activeWindowsIn != activeCount)
//   not defined : mismatch is tied low and activeWindowsIn is ignored
//
// Ports
//   clk             in  : single clock, rising edge
//   reset           in  : asynchronous, active-low
//   frameReq        in  : request to process one frame (level-sampled in IDLE)
//   memBusy         in  : image memory unavailable this cycle, pauses the scan
//   medianIn        in  : scanner median output
//   activeWindowsIn in  : scanner active-window count (cross-check only)
//   scanReset       out : active-high synchronous reset to the scanner
//   scanStart       out : scanner advance enable
//   medWrEn         out : median memory write strobe
//   medWrAddr       out : window index being written
//   medWrData       out : median bit being written
//   busy            out : controller is not IDLE
//   resultValid     out : frame result available
//   resultReady     in  : consumer accepts the result
//   activeCount     out : number of windows with median 1 (saturating)
//   frameFlag       out : activeCount >= THRESHOLD
//   mismatch        out : own count differs from activeWindowsIn
//   reqDropped      out : high in any cycle where frameReq is ignored
// -----------------------------------------------------------------------------
module median_frame_ctrl #(
    parameter int IMAGEWIDTH  = 240,
    parameter int IMAGEHEIGHT = 180,
    parameter int WINDOWSIZE  = 3,
    parameter int THRESHOLD   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameReq,
    input  logic        memBusy,
    input  logic        medianIn,
    input  logic [12:0] activeWindowsIn,
    output logic        scanReset,
    output logic        scanStart,
    output logic        medWrEn,
    output logic [12:0] medWrAddr,
    output logic        medWrData,
    output logic        busy,
    output logic        resultValid,
    input  logic        resultReady,
    output logic [12:0] activeCount,
    output logic        frameFlag,
    output logic        mismatch,
    output logic        reqDropped
);

    localparam int NUMWINDOWS = (IMAGEWIDTH / WINDOWSIZE) * (IMAGEHEIGHT / WINDOWSIZE);
    localparam int PHASES     = WINDOWSIZE * WINDOWSIZE;
    // Cycle index of the final strobe; the counter must also hold one past it.
    localparam int LASTCYCLE  = NUMWINDOWS * PHASES;
    localparam int CW         = $clog2(LASTCYCLE + 2);
    localparam int PW         = $clog2(PHASES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SCAN   = 3'd2,
        SETTLE = 3'd3,
        REPORT = 3'd4
    } stateT;

    stateT          stateReg;
    stateT          stateNext;
    logic [CW-1:0]  cycleReg;
    logic [PW-1:0]  phaseReg;
    logic [12:0]    winReg;
    logic [12:0]    countReg;

    logic           scanEn;
    logic           strobe;
    logic           lastStrobe;

    // Scanner advances only in SCAN and only while memory is available; a pause
    // freezes every counter, so a strobe that lands on a busy cycle is simply
    // re-evaluated on the next enabled cycle.
    assign scanEn     = (stateReg == SCAN) && !memBusy;

    // First median is ready once a full window period has elapsed (c = 9), and
    // then at every phase wrap: c = 9w + 9.
    assign strobe     = scanEn && (cycleReg >= CW'(PHASES)) && (phaseReg == '0);
    assign lastStrobe = strobe && (winReg == 13'(NUMWINDOWS - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        scanReset   = 1'b0;
        resultValid = 1'b0;
        case (stateReg)
            IDLE: begin
                scanReset = 1'b1;
                if (frameReq) begin
                    stateNext = CLEAR;
                end
            end
            CLEAR: begin
                scanReset = 1'b1;
                stateNext = SCAN;
            end
            SCAN: begin
                if (lastStrobe) begin
                    stateNext = SETTLE;
                end
            end
            SETTLE: begin
                stateNext = REPORT;
            end
            REPORT: begin
                resultValid = 1'b1;
                if (resultReady) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleReg <= '0;
            phaseReg <= '0;
            winReg   <= '0;
            countReg <= '0;
        end else if (stateReg == CLEAR) begin
            cycleReg <= '0;
            phaseReg <= '0;
            winReg   <= '0;
            countReg <= '0;
        end else if (scanEn) begin
            cycleReg <= cycleReg + 1'b1;
            phaseReg <= (phaseReg == PW'(PHASES - 1)) ? '0 : phaseReg + 1'b1;
            if (strobe) begin
                winReg <= winReg + 1'b1;
                if (medianIn && (countReg != 13'h1fff)) begin
                    countReg <= countReg + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------- outputs
    assign scanStart   = scanEn;
    assign medWrEn     = strobe;
    assign medWrAddr   = winReg;
    assign medWrData   = strobe & medianIn;
    assign busy        = (stateReg != IDLE);
    assign activeCount = countReg;
    assign frameFlag   = (int'({19'b0, countReg}) >= THRESHOLD);
    // Requests are never queued: anything seen outside IDLE is dropped.
    assign reqDropped  = frameReq && (stateReg != IDLE);

`ifdef MEDCTRL_CROSSCHECK_EN
    logic mismatchReg;

    // Scanner count is compared once the scanner has been frozen in SETTLE,
    // then held through REPORT until the next frame's CLEAR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatchReg <= 1'b0;
        end else if (stateReg == CLEAR) begin
            mismatchReg <= 1'b0;
        end else if (stateReg == SETTLE) begin
            mismatchReg <= (activeWindowsIn != countReg);
        end
    end

    assign mismatch = mismatchReg;
`else
    logic unusedActiveWindows;

    assign unusedActiveWindows = ^activeWindowsIn;
    assign mismatch            = 1'b0;
`endif

endmodule

// File: tb/tb_median_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_frame_ctrl
//
// Scoreboard bench for median_frame_ctrl. Each frame pushes its expected
// median-memory writes and its expected frame result into queues; an
// independent monitor pops and compares whenever the DUT strobes a write or
// completes a result handshake. Directed checks cover reset state, latency,
// pauses, report hold and mid-frame abort.
// -----------------------------------------------------------------------------
module tb_median_frame_ctrl;

    localparam int W       = 36;
    localparam int H       = 36;
    localparam int WS      = 3;
    localparam int TH      = 100;
    localparam int N       = (W / WS) * (H / WS);
    localparam int SCANLEN = N * WS * WS + 1;
    localparam int LAT     = 2 + SCANLEN + 1;

`ifdef MEDCTRL_CROSSCHECK_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        frameReq;
    logic        memBusy;
    logic        medianIn = 1'b0;
    logic [12:0] activeWindowsIn;
    logic        scanReset;
    logic        scanStart;
    logic        medWrEn;
    logic [12:0] medWrAddr;
    logic        medWrData;
    logic        busy;
    logic        resultValid;
    logic        resultReady;
    logic [12:0] activeCount;
    logic        frameFlag;
    logic        mismatch;
    logic        reqDropped;

    median_frame_ctrl #(
        .IMAGEWIDTH (W),
        .IMAGEHEIGHT(H),
        .WINDOWSIZE (WS),
        .THRESHOLD  (TH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frameReq       (frameReq),
        .memBusy        (memBusy),
        .medianIn       (medianIn),
        .activeWindowsIn(activeWindowsIn),
        .scanReset      (scanReset),
        .scanStart      (scanStart),
        .medWrEn        (medWrEn),
        .medWrAddr      (medWrAddr),
        .medWrData      (medWrData),
        .busy           (busy),
        .resultValid    (resultValid),
        .resultReady    (resultReady),
        .activeCount    (activeCount),
        .frameFlag      (frameFlag),
        .mismatch       (mismatch),
        .reqDropped     (reqDropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit data;
    } wrT;

    typedef struct {
        int cnt;
        bit flag;
        bit mm;
    } resT;

    wrT  wrQ[$];
    resT resQ[$];
    int  applied     = 0;
    int  miscompares = 0;
    int  scanHigh    = 0;
    int  medLimit    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scanner model: median is 1 for every window index below medLimit.
    always @(posedge clk) begin
        #2;
        medianIn = (int'(medWrAddr) < medLimit);
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or a result.
    always @(negedge clk) begin
        if (reset) begin
            if (scanStart) scanHigh++;
            if (medWrEn) begin
                if (wrQ.size() == 0) begin
                    check("unexpected_write", 32'(medWrEn), 0);
                end else begin
                    wrT e;
                    e = wrQ.pop_front();
                    check("wr_addr", 32'(medWrAddr), e.addr);
                    check("wr_data", 32'(medWrData), 32'(e.data));
                    check("wr_while_busy", 32'(memBusy), 0);
                    $display("write addr=%0d data=%0d", medWrAddr, medWrData);
                end
            end
            if (resultValid && resultReady) begin
                if (resQ.size() == 0) begin
                    check("unexpected_result", 32'(resultValid), 0);
                end else begin
                    resT r;
                    r = resQ.pop_front();
                    check("res_count", 32'(activeCount), r.cnt);
                    check("res_flag", 32'(frameFlag), 32'(r.flag));
                    check("res_mismatch", 32'(mismatch), 32'(r.mm));
                    $display("result count=%0d flag=%0d mismatch=%0d", activeCount, frameFlag, mismatch);
                end
            end
        end
    end

    task automatic runFrame(input int limit, input int busyPct, input int delta,
                            input bit holdReport, input bit pauseAt18);
        int cyc;
        int drops;
        bit done;
        int expCnt;
        bit expFlag;
        bit expMm;
        expCnt  = (limit < N) ? limit : N;
        expFlag = (expCnt >= TH);
        expMm   = CROSS && (delta != 0);
        for (int w = 0; w < N; w++) wrQ.push_back('{w, (w < limit)});
        resQ.push_back('{expCnt, expFlag, expMm});
        medLimit        = limit;
        activeWindowsIn = 13'(expCnt + delta);
        resultReady     = !holdReport;

        @(posedge clk) #1;
        frameReq = 1'b1;
        scanHigh = 0;
        cyc      = 0;
        done     = 1'b0;
        while (!done && cyc < 4 * LAT) begin
            @(posedge clk) #1;
            cyc++;
            frameReq = 1'b0;
            if (busyPct > 0) memBusy = ($urandom_range(0, 99) < busyPct);
            else             memBusy = pauseAt18 && (cyc >= 20) && (cyc < 25);
            if (resultValid) begin
                done = 1'b1;
            end else if (pauseAt18 && cyc >= 20 && cyc <= 25) begin
                // cyc 20 is scan cycle c=18, the strobe for window 1
                @(negedge clk);
                if (cyc < 25) begin
                    check("pause_no_write", 32'(medWrEn), 0);
                end else begin
                    check("deferred_write_en", 32'(medWrEn), 1);
                    check("deferred_write_addr", 32'(medWrAddr), 1);
                end
            end
        end
        memBusy = 1'b0;
        if (!done) begin
            check("frame_timeout", 32'(resultValid), 1);
            void'(resQ.pop_back());
            wrQ.delete();
            return;
        end
        if (busyPct == 0 && !pauseAt18) check("latency", cyc, LAT);
        check("scanstart_cycles", scanHigh, SCANLEN);

        if (holdReport) begin
            drops = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk) #1;
                frameReq = (i == 5);
                @(negedge clk);
                drops += int'(reqDropped);
                check("hold_valid", 32'(resultValid), 1);
                check("hold_busy", 32'(busy), 1);
                check("hold_scanreset", 32'(scanReset), 0);
                check("hold_count", 32'(activeCount), expCnt);
                check("hold_flag", 32'(frameFlag), 32'(expFlag));
                check("hold_mismatch", 32'(mismatch), 32'(expMm));
            end
            frameReq = 1'b0;
            check("req_dropped_pulses", drops, 1);
            @(posedge clk) #1;
            resultReady = 1'b1;
        end

        @(posedge clk) #1;
        check("idle_after_accept", 32'(busy), 0);
        check("valid_after_accept", 32'(resultValid), 0);
        $display("frame limit=%0d busyPct=%0d done after %0d cycles", limit, busyPct, cyc);
    endtask

    task automatic abortFrame();
        for (int w = 0; w < N; w++) wrQ.push_back('{w, 1'b1});
        medLimit        = N;
        activeWindowsIn = '0;
        resultReady     = 1'b1;
        @(posedge clk) #1;
        frameReq = 1'b1;
        @(posedge clk) #1;
        frameReq = 1'b0;
        @(posedge clk) #1;
        repeat (500) @(posedge clk) #1;
        reset = 1'b0;
        #1;
        check("abort_scanreset", 32'(scanReset), 1);
        check("abort_scanstart", 32'(scanStart), 0);
        check("abort_wren", 32'(medWrEn), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wrQ.delete();
        @(negedge clk);
        check("post_abort_busy", 32'(busy), 0);
        check("post_abort_count", 32'(activeCount), 0);
        check("post_abort_addr", 32'(medWrAddr), 0);
        check("post_abort_valid", 32'(resultValid), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_abort_stays_idle", 32'(busy), 0);
        $display("abort at c=500 done");
    endtask

    initial begin
        reset           = 1'b0;
        frameReq        = 1'b0;
        memBusy         = 1'b0;
        activeWindowsIn = '0;
        resultReady     = 1'b1;
        @(negedge clk);
        check("rst_scanreset", 32'(scanReset), 1);
        check("rst_scanstart", 32'(scanStart), 0);
        check("rst_wren", 32'(medWrEn), 0);
        check("rst_addr", 32'(medWrAddr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(resultValid), 0);
        check("rst_count", 32'(activeCount), 0);
        check("rst_flag", 32'(frameFlag), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_dropped", 32'(reqDropped), 0);
        $display("reset state checked");
        @(posedge clk) #1;
        reset = 1'b1;

        runFrame(N,   0,  0, 1'b0, 1'b0);
        runFrame(99,  0,  0, 1'b0, 1'b0);
        runFrame(100, 0,  0, 1'b0, 1'b0);
        abortFrame();
        runFrame(50,  30, 0, 1'b0, 1'b0);
        runFrame(N,   0,  0, 1'b0, 1'b1);
        runFrame(120, 0,  1, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        check("writes_outstanding", wrQ.size(), 0);
        check("results_outstanding", resQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
